morse_decoder: RTL
==================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter UNIT_CYCLES, default 25000000, clock cycles per Morse time unit (0.5 s at 50 MHz); legal range >= 2.
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 morse_code  input  1  serial Morse line, high = mark, low = space; same clock domain as the encoder that drives it.
REQ-005 letter  output  3  last decoded letter: 000 S, 001 T, 010 U, 011 V, 100 W, 101 X, 110 Y, 111 Z.
REQ-006 letter_valid  output  1  one-cycle pulse when letter is updated.
REQ-007 decode_error  output  1  one-cycle pulse on a malformed or unmatched letter.
REQ-008 busy  output  1  high while a letter is being received (any state other than IDLE).

Function
REQ-009 morse_code SHALL be registered once (in_q); all decisions use in_q.
REQ-010 Run counter cnt SHALL equal the number of consecutive cycles in_q has held its current level, including the current cycle, saturating at 4*UNIT_CYCLES; cnt SHALL reload to 1 on every level change.
REQ-011 States: IDLE, MARK, SPACE, FLUSH.
REQ-012 IDLE: in_q rising -> MARK with symbol count 0; low -> stay.
REQ-013 MARK, in_q falls with length L = cnt of the ending run: L < 2*UNIT_CYCLES appends dot (0); 2*UNIT_CYCLES <= L < 4*UNIT_CYCLES appends dash (1); then -> SPACE.
REQ-014 MARK, cnt reaches 4*UNIT_CYCLES while high -> pulse decode_error, -> FLUSH.
REQ-015 Symbols SHALL be shifted into a 4-bit register, first symbol in the MSB of the used field, with a 3-bit symbol count.
REQ-016 Appending a fifth symbol SHALL pulse decode_error and go to FLUSH instead of SPACE.
REQ-017 SPACE: in_q rising before cnt reaches 2*UNIT_CYCLES -> MARK (intra-letter gap).
REQ-018 SPACE: cnt reaches 2*UNIT_CYCLES -> look up pattern; match loads letter and pulses letter_valid, no match pulses decode_error; -> IDLE.
REQ-019 Patterns (dot 0, dash 1): S 000, T 1, U 001, V 0001, W 011, X 1001, Y 1011, Z 1100; the symbol count SHALL be part of the match.
REQ-020 FLUSH: stay until in_q has been low for 2*UNIT_CYCLES, then -> IDLE; no output pulses in FLUSH.
REQ-021 letter_valid and decode_error SHALL be registered, never high in the same cycle, and appear the cycle after the deciding edge.
REQ-022 Latency: letter_valid SHALL rise exactly 2*UNIT_CYCLES + 2 cycles after the final falling edge of morse_code.
REQ-023 letter SHALL hold its value between valid pulses and SHALL NOT change on decode_error.

Reset
REQ-024 On reset: state IDLE, in_q 0, cnt 1, symbol register and count 0, letter 000, letter_valid 0, decode_error 0, busy 0.
REQ-025 Reset asserted mid-letter SHALL discard partial symbols with no pulse; after release, decoding restarts at the next rising edge of in_q.

Structure
REQ-026 Shared package morse_pkg SHALL hold the letter code constants, the state enumeration and the pattern/length table, shared with the encoder.
REQ-027 Pattern lookup SHALL be one combinational sub-module, morse_pattern_match (symbols, count -> letter, hit).
REQ-028 Counter width SHALL be clog2(4*UNIT_CYCLES+1) bits.

Verification (UNIT_CYCLES=4)
REQ-029 S: three 4-cycle marks separated by 4-cycle spaces, then low -> letter=000, letter_valid one cycle, 10 cycles after last falling edge.
REQ-030 Z: marks 12,12,4,4 with 4-cycle gaps -> letter=111; then Y (12,4,12,12) -> letter=110, second valid pulse.
REQ-031 Mark held 16 cycles -> decode_error one cycle, busy high until 8 low cycles elapse, letter unchanged.
REQ-032 Five 4-cycle marks with 4-cycle gaps -> decode_error on fifth falling edge, no letter_valid.
REQ-033 Single 4-cycle mark (E, unmatched) -> decode_error, no letter_valid; boundary marks of 7 and 8 cycles decode as dot and dash.
REQ-034 Reset pulse between second and third mark of S -> no pulses; following T (12-cycle mark) -> letter=001.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, FSM state codes and the
// symbol pattern table used by both decoder and encoder.
package morse_pkg;

    // Letter codes as presented on the decoder's letter output
    localparam logic [2:0] LTR_S = 3'd0;
    localparam logic [2:0] LTR_T = 3'd1;
    localparam logic [2:0] LTR_U = 3'd2;
    localparam logic [2:0] LTR_V = 3'd3;
    localparam logic [2:0] LTR_W = 3'd4;
    localparam logic [2:0] LTR_X = 3'd5;
    localparam logic [2:0] LTR_Y = 3'd6;
    localparam logic [2:0] LTR_Z = 3'd7;

    // Receiver state enumeration
    typedef logic [1:0] morse_state_t;
    localparam morse_state_t ST_IDLE  = 2'd0;
    localparam morse_state_t ST_MARK  = 2'd1;
    localparam morse_state_t ST_SPACE = 2'd2;
    localparam morse_state_t ST_FLUSH = 2'd3;

    // One table entry: symbols right-aligned (first symbol in the MSB of
    // the used field, dot 0 / dash 1) plus the number of symbols.
    typedef struct packed {
        logic [3:0] pat;
        logic [2:0] len;
    } morse_pat_t;

    // Indexed by letter code; entry 7 (Z) sits in the MSBs.
    localparam morse_pat_t [7:0] PAT_TABLE = {
        {4'b1100, 3'd4},   // Z
        {4'b1011, 3'd4},   // Y
        {4'b1001, 3'd4},   // X
        {4'b0011, 3'd3},   // W
        {4'b0001, 3'd4},   // V
        {4'b0001, 3'd3},   // U
        {4'b0001, 3'd1},   // T
        {4'b0000, 3'd3}    // S
    };

    // Maximum number of symbols a letter may carry
    localparam logic [2:0] MAX_SYMBOLS = 3'd4;

endpackage

// File: rtl/morse_pattern_match.sv
// Combinational pattern lookup: symbol field plus symbol count to letter.
// Unused high bits of the symbol field are zero, so a whole-field compare
// together with the count gives an exact match.
module morse_pattern_match
    import morse_pkg::*;
(
    input  logic [3:0] symbols,
    input  logic [2:0] count,
    output logic [2:0] letter,
    output logic       hit
);

    // Scan the table; the first matching entry wins
    always_comb begin
        letter = LTR_S;
        hit    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && PAT_TABLE[i].pat == symbols && PAT_TABLE[i].len == count) begin
                hit    = 1'b1;
                letter = 3'(i);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: measures mark/space run lengths on a registered copy of
// the line, assembles dots and dashes into a letter and reports either a
// decoded letter or a decode error, one cycle after the deciding edge.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       morse_code,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       decode_error,
    output logic       busy
);

    localparam int              CNT_W   = $clog2(4 * UNIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(4 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(2 * UNIT_CYCLES);

    logic             in_q;
    logic [CNT_W-1:0] cnt;
    logic             run_long;   // previous cycle's run was >= 2 units
    morse_state_t     state;
    logic [3:0]       sym;
    logic [2:0]       sym_cnt;
    logic             eval_q;     // letter boundary reached, look up next cycle
    logic             err_q;      // malformed letter detected, report next cycle
    logic [2:0]       match_letter;
    logic             match_hit;

    // Line register and run-length counter aligned with in_q
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_q     <= 1'b0;
            cnt      <= CNT_W'(1);
            run_long <= 1'b0;
        end else begin
            in_q <= morse_code;
            if (morse_code != in_q)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            // When MARK sees in_q low, this still describes the last high cycle
            run_long <= (cnt >= CNT_GAP);
        end
    end

    // Receive FSM: collects symbols and flags letter boundaries / errors
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sym     <= 4'd0;
            sym_cnt <= 3'd0;
            eval_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            eval_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_q) begin
                        state   <= ST_MARK;
                        sym     <= 4'd0;
                        sym_cnt <= 3'd0;
                    end
                end
                ST_MARK: begin
                    if (!in_q) begin
                        if (sym_cnt == MAX_SYMBOLS) begin
                            err_q <= 1'b1;
                            state <= ST_FLUSH;
                        end else begin
                            sym     <= {sym[2:0], run_long};
                            sym_cnt <= sym_cnt + 3'd1;
                            state   <= ST_SPACE;
                        end
                    end else if (cnt == CNT_MAX) begin
                        err_q <= 1'b1;
                        state <= ST_FLUSH;
                    end
                end
                ST_SPACE: begin
                    if (in_q) begin
                        state <= ST_MARK;
                    end else if (cnt >= CNT_GAP) begin
                        eval_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (!in_q && cnt >= CNT_GAP)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    morse_pattern_match u_match (
        .symbols (sym),
        .count   (sym_cnt),
        .letter  (match_letter),
        .hit     (match_hit)
    );

    // Registered result pulses; letter only moves on a successful match
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            letter       <= LTR_S;
            letter_valid <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            letter_valid <= eval_q & match_hit;
            decode_error <= err_q | (eval_q & ~match_hit);
            if (eval_q && match_hit)
                letter <= match_letter;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
